zeta_addr_seq: RTL and testbench
================================

Name: zeta_addr_seq

Overview:
- Requester side of the per-stage twiddle ROMs: generates the two lane read addresses for every NTT stage of a streaming radix-2 pipeline.
- Tracks the ROM read latency and emits per-stage zeta_valid aligned with the returned rom_data.
- Sits between the NTT stage controllers (beat strobes) and the zeta ROM bank (1-cycle registered read, stage 0 constant).

Parameters:
- NTT_STAGE_CNT, 8, number of butterfly stages S; N = 2^S coefficients, 2^(S-1) butterflies per stage, 2 butterflies per beat, so 2^(S-2) beats per frame.
- ADDR_W, NTT_STAGE_CNT-1, address width per lane; stage i uses the low i bits, upper bits zero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  NTT_STAGE_CNT  per-stage frame-start pulse.
- inv  in  1  0 = forward NTT order, 1 = inverse order; sampled per stage at frame start.
- beat_en  in  NTT_STAGE_CNT  per-stage beat strobe; one butterfly pair consumed.
- rom_addr  out  [2][NTT_STAGE_CNT] x ADDR_W  lane0/lane1 ROM address per stage; registered.
- addr_valid  out  NTT_STAGE_CNT  rom_addr[*][i] is a live request this cycle.
- zeta_valid  out  NTT_STAGE_CNT  ROM data for stage i is valid this cycle.
- frame_done  out  NTT_STAGE_CNT  one-cycle pulse on the cycle the last beat's address is issued.
- busy  out  NTT_STAGE_CNT  stage i is in RUN.
- err  out  NTT_STAGE_CNT  sticky protocol error per stage.

Behaviour:
- Reset (rst_n=0 at a clk edge): every stage goes to IDLE with beat counter 0 and latched inv 0. rom_addr, addr_valid, zeta_valid, frame_done, busy and err all clear to 0. Reset mid-frame aborts the frame; no further valids issue.
- Per-stage FSM, independent for i = 0..S-1, with a beat counter b of width S-2.
- IDLE:
  - start[i] -> RUN, b=0, latch inv.
  - beat_en[i] alone is ignored and sets err[i].
  - If start[i] and beat_en[i] arrive together, the beat is accepted as beat 0 in the same cycle.
- RUN:
  - beat_en[i] accepts beat b and increments b.
  - The beat with b = 2^(S-2)-1 returns the stage to IDLE, with b wrapping to 0.
  - start[i] in RUN is ignored and sets err[i].
  - If start[i] coincides with the final beat, the next frame begins immediately: stay in RUN, b=0, re-latch inv.
- Address math for an accepted beat b:
  - Butterfly index k_l = 2b + l for l in {0,1}.
  - idx_l = k_l >> (S-1-i), truncated to i bits.
  - If inv is latched: idx_l = (2^i - 1) - idx_l.
  - Stage 0 always produces 0.
- Latency:
  - Beat accepted at cycle t -> rom_addr and addr_valid[i] at t+1.
  - zeta_valid[i] at t+2, matching the ROM's registered read.
  - frame_done[i] at t+1 of the final beat.
  - rom_addr holds its last value when addr_valid is 0.
  - Back-to-back beats give fully pipelined, one-per-cycle throughput.
- busy[i] is 1 from the cycle after start is accepted until the cycle after the final beat, unless a new frame chains.
- err bits clear only on reset.

Test Plan:
- Reset, then S=8, stage 7 forward: start[7] plus 64 consecutive beat_en[7] -> addr pairs (0,1),(2,3)…(126,127) at t+1; zeta_valid[7] at t+2; frame_done[7] with pair (126,127); busy[7] drops after.
- S=8, stage 1 forward: beats 0..31 -> (0,0); beats 32..63 -> (1,1). Same frame with inv=1 -> (1,1) then (0,0).
- S=8, stage 3 inverse with gapped beat_en (every other cycle): beat 0 -> (7,7), beat 8 -> (6,6). No addr_valid or zeta_valid on gap cycles; the counter must not advance on gaps.
- Protocol errors: beat_en[2] while IDLE -> err[2]=1, no addr_valid. start[4] mid-frame -> err[4]=1, counter unchanged. Other stages' err remain 0.
- Chained frames: start[5] with the final beat of frame 1 -> next cycle's beat is beat 0 of frame 2, busy[5] stays 1, inv re-latched.
- Reset asserted at beat 20 of stage 6 -> next cycle all outputs 0. A new start resumes from beat 0 with correct addresses.

Source files
------------

// File: rtl/zeta_addr_seq_if.sv
// Bundle between the NTT stage controllers and the zeta address sequencer.
// The sequencer takes the slave modport; the stage controllers take the master modport.
interface zeta_addr_seq_if #(
  parameter int NTT_STAGE_CNT = 8,
  parameter int ADDR_W        = NTT_STAGE_CNT - 1
);
  logic [NTT_STAGE_CNT-1:0]                   start;
  logic                                       inv;
  logic [NTT_STAGE_CNT-1:0]                   beat_en;
  logic [1:0][NTT_STAGE_CNT-1:0][ADDR_W-1:0]  rom_addr;
  logic [NTT_STAGE_CNT-1:0]                   addr_valid;
  logic [NTT_STAGE_CNT-1:0]                   zeta_valid;
  logic [NTT_STAGE_CNT-1:0]                   frame_done;
  logic [NTT_STAGE_CNT-1:0]                   busy;
  logic [NTT_STAGE_CNT-1:0]                   err;

  modport master (
    output start, inv, beat_en,
    input  rom_addr, addr_valid, zeta_valid, frame_done, busy, err
  );

  modport slave (
    input  start, inv, beat_en,
    output rom_addr, addr_valid, zeta_valid, frame_done, busy, err
  );
endinterface

// File: rtl/zeta_addr_seq.sv
// Per-stage twiddle ROM address sequencer for a streaming radix-2 NTT pipeline;
// issues two lane addresses per accepted beat and tracks the 1-cycle ROM read.
module zeta_addr_seq #(
  parameter int NTT_STAGE_CNT = 8,
  parameter int ADDR_W        = NTT_STAGE_CNT - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  zeta_addr_seq_if.slave   bus
);
  localparam int S      = NTT_STAGE_CNT;
  localparam int BEAT_W = S - 2;
  localparam int K_W    = S - 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = '1;
  localparam logic [0:0]        ST_IDLE   = 1'b0;
  localparam logic [0:0]        ST_RUN    = 1'b1;

  // Twiddle index of butterfly k = 2b+lane for a stage: top 'stage' bits of k,
  // mirrored within the stage's range for the inverse transform.
  function automatic logic [ADDR_W-1:0] zeta_idx(
    input logic [BEAT_W-1:0] b,
    input logic              lane,
    input int                stage,
    input logic              inv_sel
  );
    logic [K_W-1:0] k;
    logic [K_W-1:0] mask;
    logic [K_W-1:0] idx;
    k    = {b, lane};
    mask = ~({K_W{1'b1}} << stage);
    idx  = (k >> (K_W - stage)) & mask;
    if (inv_sel)
      idx = ~idx & mask;
    return ADDR_W'(idx);
  endfunction

  logic [0:0]        state_q [S];
  logic [BEAT_W-1:0] beat_q  [S];
  logic [S-1:0]      inv_q;
  logic [S-1:0]      err_q;

  logic [S-1:0]      accept_p0;
  logic [S-1:0]      last_p0;
  logic [BEAT_W-1:0] cur_b_p0   [S];
  logic [S-1:0]      cur_inv_p0;
  logic [ADDR_W-1:0] addr0_p0   [S];
  logic [ADDR_W-1:0] addr1_p0   [S];
  logic [S-1:0]      busy_w;

  logic [1:0][S-1:0][ADDR_W-1:0] rom_addr_p1;
  logic [S-1:0]                  vld_p1;
  logic [S-1:0]                  done_p1;
  logic [S-1:0]                  vld_p2;

  // p0: beat acceptance and address math; an IDLE stage taking start+beat uses beat 0 and the live inv
  always_comb begin
    accept_p0  = '0;
    last_p0    = '0;
    cur_inv_p0 = '0;
    busy_w     = '0;
    for (int i = 0; i < S; i++) begin
      cur_b_p0[i]   = (state_q[i] == ST_IDLE) ? '0 : beat_q[i];
      cur_inv_p0[i] = (state_q[i] == ST_IDLE) ? bus.inv : inv_q[i];
      accept_p0[i]  = bus.beat_en[i] & ((state_q[i] == ST_RUN) | bus.start[i]);
      last_p0[i]    = accept_p0[i] & (cur_b_p0[i] == LAST_BEAT);
      addr0_p0[i]   = zeta_idx(cur_b_p0[i], 1'b0, i, cur_inv_p0[i]);
      addr1_p0[i]   = zeta_idx(cur_b_p0[i], 1'b1, i, cur_inv_p0[i]);
      busy_w[i]     = (state_q[i] == ST_RUN);
    end
  end

  // p1: registered request; p2: ROM data valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < S; i++) begin
        state_q[i] <= ST_IDLE;
        beat_q[i]  <= '0;
      end
      inv_q       <= '0;
      err_q       <= '0;
      rom_addr_p1 <= '0;
      vld_p1      <= '0;
      done_p1     <= '0;
      vld_p2      <= '0;
    end else begin
      vld_p1  <= accept_p0;
      done_p1 <= last_p0;
      vld_p2  <= vld_p1;
      for (int i = 0; i < S; i++) begin
        if (accept_p0[i]) begin
          rom_addr_p1[0][i] <= addr0_p0[i];
          rom_addr_p1[1][i] <= addr1_p0[i];
        end
        case (state_q[i])
          ST_IDLE: begin
            if (bus.start[i]) begin
              state_q[i] <= ST_RUN;
              inv_q[i]   <= bus.inv;
              beat_q[i]  <= accept_p0[i] ? BEAT_W'(1) : '0;
            end else if (bus.beat_en[i]) begin
              err_q[i] <= 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.beat_en[i]) begin
              if (last_p0[i]) begin
                beat_q[i] <= '0;
                if (bus.start[i])
                  inv_q[i] <= bus.inv;
                else
                  state_q[i] <= ST_IDLE;
              end else begin
                beat_q[i] <= beat_q[i] + BEAT_W'(1);
              end
            end
            if (bus.start[i] && !last_p0[i])
              err_q[i] <= 1'b1;
          end
          default: state_q[i] <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr   = rom_addr_p1;
  assign bus.addr_valid = vld_p1;
  assign bus.zeta_valid = vld_p2;
  assign bus.frame_done = done_p1;
  assign bus.busy       = busy_w;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_zeta_addr_seq.sv
// Scoreboard bench for zeta_addr_seq: the driver queues expected address/zeta
// responses per accepted beat, a negedge monitor pops and compares them.
module tb_zeta_addr_seq;
  localparam int S = 8;

  typedef struct {
    int stage;
    int cyc;
    int a0;
    int a1;
    bit done;
  } addr_exp_t;

  typedef struct {
    int stage;
    int cyc;
  } zeta_exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  addr_exp_t aq[$];
  zeta_exp_t zq[$];

  zeta_addr_seq_if #(.NTT_STAGE_CNT(S)) bus ();

  zeta_addr_seq #(.NTT_STAGE_CNT(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every live output must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int s = 0; s < S; s++) begin
      if (bus.addr_valid[s]) begin
        if (aq.size() == 0) begin
          chk("unexpected_addr_valid", s, -1);
        end else begin
          addr_exp_t e;
          e = aq.pop_front();
          chk("addr_stage", s, e.stage);
          chk("addr_cycle", cyc, e.cyc);
          chk("addr_lane0", int'(bus.rom_addr[0][s]), e.a0);
          chk("addr_lane1", int'(bus.rom_addr[1][s]), e.a1);
          chk("frame_done", int'(bus.frame_done[s]), int'(e.done));
        end
      end else if (bus.frame_done[s]) begin
        chk("frame_done_without_valid", s, -1);
      end
      if (bus.zeta_valid[s]) begin
        if (zq.size() == 0) begin
          chk("unexpected_zeta_valid", s, -1);
        end else begin
          zeta_exp_t z;
          z = zq.pop_front();
          chk("zeta_stage", s, z.stage);
          chk("zeta_cycle", cyc, z.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start   = '0;
    bus.beat_en = '0;
    bus.inv     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    clear_inputs();
    for (int k = 0; k < n; k++) tick();
  endtask

  // One accepted beat on stage s with its hand-derived lane addresses.
  task automatic beat_cycle(input int s, input bit st, input bit iv,
                            input int a0, input int a1, input bit done,
                            input bit with_zeta);
    addr_exp_t e;
    zeta_exp_t z;
    clear_inputs();
    bus.start[s]   = st;
    bus.beat_en[s] = 1'b1;
    bus.inv        = iv;
    e.stage = s; e.cyc = cyc + 1; e.a0 = a0; e.a1 = a1; e.done = done;
    aq.push_back(e);
    if (with_zeta) begin
      z.stage = s; z.cyc = cyc + 2;
      zq.push_back(z);
    end
    tick();
    clear_inputs();
  endtask

  // Cycle with no beat expected to be accepted.
  task automatic raw_cycle(input logic [S-1:0] st, input logic [S-1:0] be, input bit iv);
    bus.start   = st;
    bus.beat_en = be;
    bus.inv     = iv;
    tick();
    clear_inputs();
  endtask

  task automatic check_all_clear(input string tag);
    chk({tag, "_busy"},       int'(bus.busy),       0);
    chk({tag, "_err"},        int'(bus.err),        0);
    chk({tag, "_addr_valid"}, int'(bus.addr_valid), 0);
    chk({tag, "_zeta_valid"}, int'(bus.zeta_valid), 0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    chk({tag, "_rom_addr"},   int'(|bus.rom_addr),  0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    tick(); tick(); tick();
    check_all_clear("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    // Stage 7 forward: pair (2b, 2b+1)
    for (int b = 0; b < 64; b++) begin
      beat_cycle(7, b == 0, 1'b0, 2 * b, 2 * b + 1, b == 63, 1'b1);
      if (b == 0)  chk("s7_busy_after_start", int'(bus.busy[7]), 1);
      if (b == 63) chk("s7_busy_after_last",  int'(bus.busy[7]), 0);
    end
    idle_cycles(3);

    // Stage 1 forward (inv toggled after start must not matter), then inverse
    for (int b = 0; b < 64; b++)
      beat_cycle(1, b == 0, b != 0, (b < 32) ? 0 : 1, (b < 32) ? 0 : 1, b == 63, 1'b1);
    idle_cycles(2);
    for (int b = 0; b < 64; b++)
      beat_cycle(1, b == 0, b == 0, (b < 32) ? 1 : 0, (b < 32) ? 1 : 0, b == 63, 1'b1);
    idle_cycles(3);

    // Stage 3 inverse with a gap after every beat: 7 - b/8
    for (int b = 0; b < 64; b++) begin
      beat_cycle(3, b == 0, b == 0, 7 - b / 8, 7 - b / 8, b == 63, 1'b1);
      idle_cycles(1);
    end
    idle_cycles(3);

    // Protocol errors
    raw_cycle(8'h00, 8'h04, 1'b0);
    chk("idle_beat_err2",      int'(bus.err[2]),        1);
    chk("idle_beat_no_valid",  int'(bus.addr_valid[2]), 0);
    chk("idle_beat_busy2",     int'(bus.busy[2]),       0);
    for (int b = 0; b < 64; b++) begin
      if (b == 10) begin
        raw_cycle(8'h10, 8'h00, 1'b1);
        chk("midframe_start_err4",  int'(bus.err[4]),  1);
        chk("midframe_start_busy4", int'(bus.busy[4]), 1);
      end
      beat_cycle(4, b == 0, 1'b0, b / 4, b / 4, b == 63, 1'b1);
    end
    idle_cycles(3);
    chk("err_vector_isolated", int'(bus.err), 8'h14);

    // Stage 5 chained frames: forward b/2, then inverse 31 - b/2
    for (int b = 0; b < 64; b++)
      beat_cycle(5, (b == 0) || (b == 63), b == 63, b / 2, b / 2, b == 63, 1'b1);
    chk("chain_busy5", int'(bus.busy[5]), 1);
    for (int b = 0; b < 64; b++)
      beat_cycle(5, 1'b0, 1'b0, 31 - b / 2, 31 - b / 2, b == 63, 1'b1);
    chk("chain_end_busy5", int'(bus.busy[5]), 0);
    idle_cycles(3);

    // Stage 6 reset mid-frame at beat 20; beat 19's zeta is killed by the reset
    for (int b = 0; b < 20; b++)
      beat_cycle(6, b == 0, 1'b0, b, b, 1'b0, b != 19);
    clear_inputs();
    bus.beat_en[6] = 1'b1;
    rst_n = 1'b0;
    tick();
    clear_inputs();
    check_all_clear("midframe_reset");
    rst_n = 1'b1;
    idle_cycles(2);
    chk("post_reset_no_zeta", int'(bus.zeta_valid), 0);
    for (int b = 0; b < 64; b++)
      beat_cycle(6, b == 0, 1'b0, b, b, b == 63, 1'b1);
    idle_cycles(4);
    chk("final_err_clear", int'(bus.err), 0);
    chk("addr_queue_drained", aq.size(), 0);
    chk("zeta_queue_drained", zq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
